vga_timing_gen: RTL

Parametrised VGA raster timing generator. It sits between the frame/pixel source logic and the DE2-115 VGA DAC pins. It issues per-pixel requests with coordinates ahead of display time, and accepts RGB returned a fixed `PIX_LAT` cycles later. Sync and blank are delayed by the same amount so that pixel data and raster geometry stay aligned. It supports arbitrary mode timings, selectable sync polarity, and clean start/stop on frame boundaries.

---
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: early pixel requests, display side
// delayed by PIX_LAT+1 clocks so returned RGB lines up with syncs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_enable,
  input  logic [7:0]    i_r,
  input  logic [7:0]    i_g,
  input  logic [7:0]    i_b,
  output logic          o_req,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_frame_end,
  output logic [15:0]   o_frame_cnt,
  output logic          o_busy,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FRONT);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FRONT);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [31:0]   hx, vx;
  logic          running, h_last, v_last, wrap, active;
  logic [2:0]    tap, dly;

  always_comb begin
    hx      = 32'(hcnt_q);
    vx      = 32'(vcnt_q);
    running = (state_q != IDLE);
    h_last  = (hx == 32'(H_TOTAL - 1));
    v_last  = (vx == 32'(V_TOTAL - 1));
    wrap    = running && h_last && v_last;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = wrap ? IDLE : STOP;
      STOP:    if (wrap) state_d = IDLE;
               else if (i_enable) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (running) begin
      hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
      if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
      if (wrap) fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // request side is combinational off the counters (no added latency)
  always_comb begin
    active = running
          && (hx < 32'(H_ACTIVE))
          && (vx < 32'(V_ACTIVE));
    o_req         = active;
    o_x           = active ? CW'(hcnt_q) : '0;
    o_y           = active ? CW'(vcnt_q) : '0;
    o_line_start  = active && (hcnt_q == '0);
    o_frame_start = active && (hcnt_q == '0)
                 && (vcnt_q == '0);
    o_frame_end   = active
                 && (hx == 32'(H_ACTIVE - 1))
                 && (vx == 32'(V_ACTIVE - 1));
    o_frame_cnt   = fcnt_q;
    o_busy        = running;
    tap[2] = running && (hx >= HS_BEG)
          && (hx < HS_END);
    tap[1] = running && (vx >= VS_BEG)
          && (vx < VS_END);
    tap[0] = active;
  end

  generate
    if (PIX_LAT == 0) begin : g_lat0
      assign dly = tap;
    end else if (PIX_LAT == 1) begin : g_lat1
      logic [2:0] sr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= tap;
      end
      assign dly = sr_q;
    end else begin : g_latn
      logic [3*PIX_LAT-1:0] sr_q, sr_d;
      always_comb sr_d = {sr_q[3*PIX_LAT-4:0], tap};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
      end
      assign dly = sr_q[3*PIX_LAT-1 -: 3];
    end
  endgenerate

  logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       hs_q, vs_q, bn_q, hs_d, vs_d, bn_d;

  always_comb begin
    r_d  = dly[0] ? i_r : 8'd0;
    g_d  = dly[0] ? i_g : 8'd0;
    b_d  = dly[0] ? i_b : 8'd0;
    hs_d = dly[2] ? HS_POL : ~HS_POL;
    vs_d = dly[1] ? VS_POL : ~VS_POL;
    bn_d = dly[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      bn_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      bn_q <= bn_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = bn_q;
  assign VGA_SYNC_N  = 1'b0;

endmodule
